// File: rtl/display_pkg.sv
// Shared types and constants for the 4-digit 7-segment scan controller.
package display_pkg;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_DEAD,
    ST_SHOW
  } state_t;

  localparam int unsigned N_DIGITS   = 4;
  localparam logic [3:0]  ANODES_OFF = 4'b1111;

endpackage

// File: rtl/decodificador.sv
// Hex nibble to active-low 7-segment pattern {g,f,e,d,c,b,a} for a common-anode display.
module decodificador (
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg_c
);

  always_comb begin
    o_seg_c = 7'b1111111;
    case (i_bcd)
      4'h0: o_seg_c = 7'b1000000;
      4'h1: o_seg_c = 7'b1111001;
      4'h2: o_seg_c = 7'b0100100;
      4'h3: o_seg_c = 7'b0110000;
      4'h4: o_seg_c = 7'b0011001;
      4'h5: o_seg_c = 7'b0010010;
      4'h6: o_seg_c = 7'b0000010;
      4'h7: o_seg_c = 7'b1111000;
      4'h8: o_seg_c = 7'b0000000;
      4'h9: o_seg_c = 7'b0010000;
      4'hA: o_seg_c = 7'b0001000;
      4'hB: o_seg_c = 7'b0000011;
      4'hC: o_seg_c = 7'b1000110;
      4'hD: o_seg_c = 7'b0100001;
      4'hE: o_seg_c = 7'b0000110;
      default: o_seg_c = 7'b0001110;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan of four 7-segment digits through one shared decoder,
// with dead time between digits and frame-boundary commit of double-buffered data.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned DWELL = 1000,
  parameter int unsigned DEAD  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] data_in,
  input  logic [3:0]  blank_in,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        pending,
  output logic        frame_done
);

  localparam int unsigned MAX_PH   = (DEAD > DWELL) ? DEAD : DWELL;
  localparam int unsigned CW       = $clog2(MAX_PH + 1);
  localparam logic [1:0]  LAST_IDX = 2'(N_DIGITS - 1);

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_idx;
  logic [15:0]     r_act_data;
  logic [3:0]      r_act_blank;
  logic [15:0]     r_shd_data;
  logic [3:0]      r_shd_blank;

  state_t          w_state_nx;
  logic [CW-1:0]   w_cnt_nx;
  logic [1:0]      w_idx_nx;
  logic            w_frame_end;
  logic            w_commit;
  logic [15:0]     w_act_data_nx;
  logic [3:0]      w_act_blank_nx;
  logic [3:0]      w_an_nx;
  logic [3:0]      w_dec_in;
  logic [6:0]      w_seg_c;

  // Next-state: en low overrides everything and parks the scan at digit 0.
  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_idx_nx    = r_idx;
    w_frame_end = 1'b0;
    if (!en) begin
      w_state_nx = ST_OFF;
      w_cnt_nx   = '0;
      w_idx_nx   = '0;
    end else begin
      case (r_state)
        ST_OFF: begin
          w_state_nx = ST_DEAD;
          w_cnt_nx   = '0;
          w_idx_nx   = '0;
        end
        ST_DEAD: begin
          if (r_cnt == CW'(DEAD - 1)) begin
            w_state_nx = ST_SHOW;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = r_cnt + CW'(1);
          end
        end
        ST_SHOW: begin
          if (r_cnt == CW'(DWELL - 1)) begin
            w_state_nx  = ST_DEAD;
            w_cnt_nx    = '0;
            w_idx_nx    = r_idx + 2'd1;
            w_frame_end = (r_idx == LAST_IDX);
          end else begin
            w_cnt_nx = r_cnt + CW'(1);
          end
        end
        default: begin
          w_state_nx = ST_OFF;
          w_cnt_nx   = '0;
          w_idx_nx   = '0;
        end
      endcase
    end
  end

  // Commit happens while idle or at a frame boundary; a same-cycle load goes to the shadow only.
  always_comb begin
    w_commit       = r_pending_c();
    w_act_data_nx  = w_commit ? r_shd_data  : r_act_data;
    w_act_blank_nx = w_commit ? r_shd_blank : r_act_blank;
  end

  function automatic logic r_pending_c();
    return pending && ((r_state == ST_OFF) || w_frame_end);
  endfunction

  // Decode from next-cycle digit/data so seg is already valid in the first DEAD cycle.
  always_comb begin
    w_dec_in = w_act_data_nx[{w_idx_nx, 2'b00} +: 4];
    w_an_nx  = ANODES_OFF;
    if (w_state_nx == ST_SHOW && !w_act_blank_nx[w_idx_nx]) begin
      w_an_nx[w_idx_nx] = 1'b0;
    end
  end

  decodificador u_dec (
    .i_bcd   (w_dec_in),
    .o_seg_c (w_seg_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_OFF;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_act_data  <= '0;
      r_act_blank <= '0;
      r_shd_data  <= '0;
      r_shd_blank <= '0;
      pending     <= 1'b0;
      seg         <= 7'b0000000;
      an          <= ANODES_OFF;
      frame_done  <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_idx       <= w_idx_nx;
      r_act_data  <= w_act_data_nx;
      r_act_blank <= w_act_blank_nx;
      if (load) begin
        r_shd_data  <= data_in;
        r_shd_blank <= blank_in;
      end
      pending    <= load | (pending & ~w_commit);
      seg        <= w_seg_c;
      an         <= w_an_nx;
      frame_done <= w_frame_end;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with DWELL=3, DEAD=1 (16-cycle frame).
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [15:0] data_in;
  logic [3:0]  blank_in;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        pending;
  logic        frame_done;

  int n_checks = 0;
  int n_errors = 0;

  display_scan_ctrl #(.DWELL(3), .DEAD(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .data_in    (data_in),
    .blank_in   (blank_in),
    .seg        (seg),
    .an         (an),
    .pending    (pending),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] exp_seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  // Checks n cycles of a frame starting at its first DEAD cycle (sampled on negedge),
  // optionally driving up to two loads at given cycle offsets.
  task automatic check_frame(input int fr, input logic [15:0] d, input logic [3:0] b,
                             input bit fd0, input bit pend0, input int n,
                             input int lk1, input logic [15:0] ld1, input logic [3:0] lb1,
                             input int lk2, input logic [15:0] ld2, input logic [3:0] lb2);
    for (int k = 0; k < n; k++) begin
      int          dg;
      bit          show;
      logic [3:0]  exp_an;
      logic [15:0] dd;
      bit          ep;
      dg     = k / 4;
      show   = (k % 4) != 0;
      dd     = d;
      exp_an = 4'b1111;
      if (show && !b[dg]) exp_an[dg] = 1'b0;
      ep = pend0 || (lk1 >= 0 && k > lk1) || (lk2 >= 0 && k > lk2);
      check($sformatf("an f%0d k%0d", fr, k), int'(an), int'(exp_an));
      check($sformatf("seg f%0d k%0d", fr, k), int'(seg), int'(exp_seg(dd[4*dg +: 4])));
      check($sformatf("frame_done f%0d k%0d", fr, k), int'(frame_done), int'(fd0 && k == 0));
      check($sformatf("pending f%0d k%0d", fr, k), int'(pending), int'(ep));
      load = 1'b0;
      if (k == lk1) begin
        load = 1'b1; data_in = ld1; blank_in = lb1;
      end
      if (k == lk2) begin
        load = 1'b1; data_in = ld2; blank_in = lb2;
      end
      @(negedge clk);
    end
    load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; load = 1'b0; data_in = '0; blank_in = '0;
    repeat (2) @(negedge clk);
    check("rst seg", int'(seg), 0);
    check("rst an", int'(an), 'hF);
    check("rst pending", int'(pending), 0);
    check("rst frame_done", int'(frame_done), 0);
    rst_n = 1'b1;

    // 1: load while idle, then enable; commit happens on the OFF->DEAD edge
    @(negedge clk);
    load = 1'b1; data_in = 16'h4321; blank_in = 4'b0000;
    @(negedge clk);
    load = 1'b0;
    check("pending after load", int'(pending), 1);
    check("an idle", int'(an), 'hF);
    en = 1'b1;
    @(negedge clk);
    check_frame(1, 16'h4321, 4'b0000, 0, 0, 16, -1, '0, '0, -1, '0, '0);
    check_frame(2, 16'h4321, 4'b0000, 1, 0, 16, -1, '0, '0, -1, '0, '0);
    // 2: blank mask takes effect next frame
    check_frame(3, 16'h4321, 4'b0000, 1, 0, 16, 5, 16'h4321, 4'b0101, -1, '0, '0);
    check_frame(4, 16'h4321, 4'b0101, 1, 0, 16, -1, '0, '0, -1, '0, '0);
    // 3: double buffering
    check_frame(5, 16'h4321, 4'b0101, 1, 0, 16, 2, 16'h1111, 4'b0000, -1, '0, '0);
    check_frame(6, 16'h1111, 4'b0000, 1, 0, 16, 6, 16'hAAAA, 4'b0000, -1, '0, '0);
    // 4: load 5555 mid-frame, then 7777 on the commit cycle
    check_frame(7, 16'hAAAA, 4'b0000, 1, 0, 16, 3, 16'h5555, 4'b0000, 15, 16'h7777, 4'b0000);
    check_frame(8, 16'h5555, 4'b0000, 1, 1, 16, -1, '0, '0, -1, '0, '0);
    check_frame(9, 16'h7777, 4'b0000, 1, 0, 16, -1, '0, '0, -1, '0, '0);
    // 5: enable drop during digit 2 SHOW
    check_frame(10, 16'h7777, 4'b0000, 1, 0, 10, -1, '0, '0, -1, '0, '0);
    check("an digit2 show", int'(an), 'hB);
    en = 1'b0;
    @(negedge clk);
    check("an after en drop", int'(an), 'hF);
    check("frame_done after en drop", int'(frame_done), 0);
    load = 1'b1; data_in = 16'h1234; blank_in = 4'b0000;
    @(negedge clk);
    load = 1'b0;
    check("pending load in OFF", int'(pending), 1);
    check("an OFF 2", int'(an), 'hF);
    check("frame_done OFF 2", int'(frame_done), 0);
    @(negedge clk);
    check("pending commit in OFF", int'(pending), 0);
    check("an OFF 3", int'(an), 'hF);
    en = 1'b1;
    @(negedge clk);
    check_frame(11, 16'h1234, 4'b0000, 0, 0, 16, -1, '0, '0, -1, '0, '0);
    // 6: async reset between edges during SHOW of digit 1
    check_frame(12, 16'h1234, 4'b0000, 1, 0, 6, 2, 16'h9999, 4'b0000, -1, '0, '0);
    check("an digit1 show", int'(an), 'hD);
    check("pending before reset", int'(pending), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async rst an", int'(an), 'hF);
    check("async rst seg", int'(seg), 0);
    check("async rst pending", int'(pending), 0);
    check("async rst frame_done", int'(frame_done), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
